// File: rtl/pos_wrap_pkg.sv
// pos_wrap_pkg: shared defaults, sum width and channel slice helper for pos_wrap_accum.
package pos_wrap_pkg;
  localparam int W_DEF = 10;
  localparam int CH_DEF = 2;
  localparam int RW_DEF = 16;
  localparam int PPR_RST_DEF = 599;
  localparam int SUM_GUARD = 2;
  localparam int SW_DEF = W_DEF + SUM_GUARD;
  localparam int SLICE_MAX = 1024;
  function automatic logic [63:0] ch_slice(input logic [SLICE_MAX-1:0] v, input int i, input int w);
    return 64'((v >> (i * w)) & ((SLICE_MAX'(1) << w) - SLICE_MAX'(1)));
  endfunction
endpackage

// File: rtl/pos_wrap_ch.sv
// pos_wrap_ch: one channel of the wrapped position accumulator.
// Optional revolution counter enabled by REV_COUNT_EN.
module pos_wrap_ch
  import pos_wrap_pkg::*;
#(
  parameter int W = W_DEF
`ifdef REV_COUNT_EN
  , parameter int RW = RW_DEF
`endif
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear_all,
  input  logic         clr,
  input  logic         in_valid,
  input  logic [W-1:0] delta,
  input  logic [W-1:0] ppr,
  output logic         pos_valid,
  output logic [W-1:0] position,
  output logic         wrap_fwd,
  output logic         wrap_rev,
  output logic         err
`ifdef REV_COUNT_EN
  , output logic [RW-1:0] rev
`endif
);
  localparam int SW = W + SUM_GUARD;
  logic [W-1:0] pos_q, pos_d;
  logic pv_q, pv_d, wf_q, wf_d, wr_q, wr_d, err_q, err_d;
  logic signed [W:0] d_ext;
  logic [W:0] d_mag;
  logic signed [SW-1:0] sum, lim;
  logic rej, over, under, accept, zap;
`ifdef REV_COUNT_EN
  logic [RW-1:0] rev_q, rev_d;
`endif
  always_comb begin
    d_ext = {delta[W-1], delta};
    d_mag = d_ext[W] ? $unsigned(-d_ext) : $unsigned(d_ext);
    sum = $signed({2'b00, pos_q}) + SW'(d_ext);
    lim = $signed({2'b00, ppr});
    rej = d_mag > {1'b0, ppr};
    zap = clear_all || clr;
    accept = in_valid && !zap;
    over = accept && !rej && (sum > lim);
    under = accept && !rej && (sum < 0);
    pv_d = accept;
    wf_d = over;
    wr_d = under;
    err_d = zap ? 1'b0 : (err_q || (accept && rej));
    pos_d = zap ? '0 :
            over ? W'(sum - lim - SW'(1)) :
            under ? W'(sum + lim + SW'(1)) :
            (accept && !rej) ? W'(sum) : pos_q;
`ifdef REV_COUNT_EN
    rev_d = zap ? '0 : over ? rev_q + RW'(1) : under ? rev_q - RW'(1) : rev_q;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q <= '0;
      pv_q <= 1'b0;
      wf_q <= 1'b0;
      wr_q <= 1'b0;
      err_q <= 1'b0;
`ifdef REV_COUNT_EN
      rev_q <= '0;
`endif
    end else begin
      pos_q <= pos_d;
      pv_q <= pv_d;
      wf_q <= wf_d;
      wr_q <= wr_d;
      err_q <= err_d;
`ifdef REV_COUNT_EN
      rev_q <= rev_d;
`endif
    end
  end
  assign position = pos_q;
  assign pos_valid = pv_q;
  assign wrap_fwd = wf_q;
  assign wrap_rev = wr_q;
  assign err = err_q;
`ifdef REV_COUNT_EN
  assign rev = rev_q;
`endif
endmodule

// File: rtl/pos_wrap_accum.sv
// pos_wrap_accum: multi-channel encoder position accumulator wrapping into 0..PPR.
// Optional REV port and revolution counters enabled by REV_COUNT_EN.
module pos_wrap_accum
  import pos_wrap_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int CH = CH_DEF,
`ifdef REV_COUNT_EN
  parameter int RW = RW_DEF,
`endif
  parameter int PPR_RST = PPR_RST_DEF
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            CFG_WE,
  input  logic [W-1:0]    PPR,
  input  logic [CH-1:0]   CLR,
  input  logic [CH-1:0]   IN_VALID,
  input  logic [CH*W-1:0] DELTA,
  output logic [CH-1:0]   POS_VALID,
  output logic [CH*W-1:0] POSITION,
  output logic [CH-1:0]   WRAP_FWD,
  output logic [CH-1:0]   WRAP_REV,
  output logic [CH-1:0]   ERR
`ifdef REV_COUNT_EN
  , output logic [CH*RW-1:0] REV
`endif
);
  logic [W-1:0] ppr_q, ppr_d;
  always_comb ppr_d = CFG_WE ? PPR : ppr_q;
  always_ff @(posedge CLK) ppr_q <= RST ? W'(PPR_RST) : ppr_d;
  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [W-1:0] delta_i;
    assign delta_i = W'(ch_slice(SLICE_MAX'(DELTA), i, W));
    pos_wrap_ch #(
      .W(W)
`ifdef REV_COUNT_EN
      , .RW(RW)
`endif
    ) u_ch (
      .clk(CLK),
      .rst(RST),
      .clear_all(CFG_WE),
      .clr(CLR[i]),
      .in_valid(IN_VALID[i]),
      .delta(delta_i),
      .ppr(ppr_q),
      .pos_valid(POS_VALID[i]),
      .position(POSITION[i*W +: W]),
      .wrap_fwd(WRAP_FWD[i]),
      .wrap_rev(WRAP_REV[i]),
      .err(ERR[i])
`ifdef REV_COUNT_EN
      , .rev(REV[i*RW +: RW])
`endif
    );
  end
endmodule

// File: tb/tb_pos_wrap_accum.sv
// tb_pos_wrap_accum: directed stimulus with a scoreboard of model-predicted outputs.
module tb_pos_wrap_accum;
  localparam int W = 10, CH = 2, RW = 16;
  logic CLK = 1'b0, RST, CFG_WE;
  logic [W-1:0] PPR;
  logic [CH-1:0] CLR, IN_VALID, POS_VALID, WRAP_FWD, WRAP_REV, ERR;
  logic [CH*W-1:0] DELTA, POSITION;
  logic [CH*RW-1:0] rev_obs;
`ifdef REV_COUNT_EN
  logic [CH*RW-1:0] REV;
  assign rev_obs = REV;
`else
  assign rev_obs = '0;
`endif
  typedef struct {
    logic [CH-1:0] pv, wf, wr, err;
    logic [CH*W-1:0] pos;
    logic [CH*RW-1:0] rev;
  } exp_t;
  exp_t sb[$];
  int tests = 0, fails = 0;
  int m_ppr = 0;
  int m_pos[CH], m_err[CH], m_rev[CH];

  pos_wrap_accum dut (
    .CLK(CLK), .RST(RST), .CFG_WE(CFG_WE), .PPR(PPR), .CLR(CLR), .IN_VALID(IN_VALID),
    .DELTA(DELTA), .POS_VALID(POS_VALID), .POSITION(POSITION), .WRAP_FWD(WRAP_FWD),
    .WRAP_REV(WRAP_REV), .ERR(ERR)
`ifdef REV_COUNT_EN
    , .REV(REV)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic r, input logic c, input int p, input logic [CH-1:0] cl,
                       input logic [CH-1:0] iv, input int d0, input int d1);
    exp_t e;
    logic signed [W-1:0] t;
    int d, s, a;
    RST = r; CFG_WE = c; PPR = W'(p); CLR = cl; IN_VALID = iv;
    DELTA = {W'(d1), W'(d0)};
    e.pv = '0; e.wf = '0; e.wr = '0;
    if (r) m_ppr = 599;
    else if (c) m_ppr = p;
    for (int i = 0; i < CH; i++) begin
      t = DELTA[i*W +: W];
      d = t;
      a = d < 0 ? -d : d;
      if (r || c || cl[i]) begin
        m_pos[i] = 0; m_err[i] = 0; m_rev[i] = 0;
      end else if (iv[i]) begin
        e.pv[i] = 1'b1;
        s = m_pos[i] + d;
        if (a > m_ppr) m_err[i] = 1;
        else if (s > m_ppr) begin m_pos[i] = s - m_ppr - 1; e.wf[i] = 1'b1; m_rev[i]++; end
        else if (s < 0) begin m_pos[i] = s + m_ppr + 1; e.wr[i] = 1'b1; m_rev[i]--; end
        else m_pos[i] = s;
      end
      e.pos[i*W +: W] = W'(m_pos[i]);
      e.err[i] = m_err[i] != 0;
      e.rev[i*RW +: RW] = RW'(m_rev[i]);
    end
`ifndef REV_COUNT_EN
    e.rev = '0;
`endif
    sb.push_back(e);
    @(posedge CLK);
    #1;
    if (sb.size() == 0) chk("scoreboard_empty", 64'd1, 64'd0);
    else begin
      e = sb.pop_front();
      chk("pos_valid", 64'(POS_VALID), 64'(e.pv));
      chk("position", 64'(POSITION), 64'(e.pos));
      chk("wrap_fwd", 64'(WRAP_FWD), 64'(e.wf));
      chk("wrap_rev", 64'(WRAP_REV), 64'(e.wr));
      chk("err", 64'(ERR), 64'(e.err));
      chk("rev", 64'(rev_obs), 64'(e.rev));
    end
  endtask

  initial begin
    cycle(1, 0, 0, 2'b00, 2'b11, 5, 5);
    chk("rst_pos", 64'(POSITION), 64'd0);
    cycle(0, 1, 599, 2'b00, 2'b00, 0, 0);
    cycle(0, 0, 0, 2'b00, 2'b01, 200, 0);
    chk("s1_200", 64'(POSITION[9:0]), 64'd200);
    cycle(0, 0, 0, 2'b00, 2'b01, -127, 0);
    chk("s1_73", 64'(POSITION[9:0]), 64'd73);
    cycle(0, 0, 0, 2'b00, 2'b01, -188, 0);
    chk("s1_485", 64'(POSITION[9:0]), 64'd485);
    chk("s1_485_wr", 64'(WRAP_REV[0]), 64'd1);
`ifdef REV_COUNT_EN
    chk("s1_rev_m1", 64'(REV[15:0]), 64'hFFFF);
`endif
    cycle(0, 0, 0, 2'b00, 2'b01, 144, 0);
    chk("s1_29", 64'(POSITION[9:0]), 64'd29);
    chk("s1_29_wf", 64'(WRAP_FWD[0]), 64'd1);
    cycle(0, 0, 0, 2'b00, 2'b00, 7, 7);
    chk("idle_pv", 64'(POS_VALID), 64'd0);
    cycle(0, 0, 0, 2'b11, 2'b00, 0, 0);
    cycle(0, 0, 0, 2'b00, 2'b01, -127, 0);
    chk("b_473", 64'(POSITION[9:0]), 64'd473);
    cycle(0, 0, 0, 2'b00, 2'b01, 126, 0);
    chk("b_599", 64'(POSITION[9:0]), 64'd599);
    cycle(0, 0, 0, 2'b00, 2'b01, 1, 0);
    chk("b_fwd0", 64'(POSITION[9:0]), 64'd0);
    cycle(0, 0, 0, 2'b00, 2'b01, -1, 0);
    chk("b_rev599", 64'(POSITION[9:0]), 64'd599);
    cycle(0, 0, 0, 2'b00, 2'b01, 0, 0);
    chk("zero_delta_pv", 64'(POS_VALID[0]), 64'd1);
    cycle(0, 1, 399, 2'b00, 2'b00, 0, 0);
    cycle(0, 0, 0, 2'b00, 2'b01, -450, 0);
    chk("e_err", 64'(ERR[0]), 64'd1);
    chk("e_pos", 64'(POSITION[9:0]), 64'd0);
    cycle(0, 0, 0, 2'b01, 2'b00, 0, 0);
    chk("e_clr", 64'(ERR[0]), 64'd0);
    cycle(0, 0, 0, 2'b00, 2'b01, 200, 0);
    chk("e_200", 64'(POSITION[9:0]), 64'd200);
    cycle(0, 0, 0, 2'b00, 2'b01, -512, 0);
    chk("min_delta_err", 64'(ERR[0]), 64'd1);
    cycle(0, 0, 0, 2'b00, 2'b01, 399, 0);
    cycle(0, 0, 0, 2'b00, 2'b01, -399, 0);
    cycle(0, 0, 0, 2'b01, 2'b00, 0, 0);
    cycle(0, 0, 0, 2'b00, 2'b11, 5, -5);
    chk("two_ch0", 64'(POSITION[9:0]), 64'd5);
    chk("two_ch1", 64'(POSITION[19:10]), 64'd395);
    chk("two_wr", 64'(WRAP_REV), 64'b10);
    cycle(1, 1, 100, 2'b00, 2'b11, 3, 3);
    chk("rst_wins", 64'(POSITION), 64'd0);
    cycle(0, 0, 0, 2'b00, 2'b01, -1, 0);
    chk("rst_ppr599", 64'(POSITION[9:0]), 64'd599);
    cycle(0, 0, 0, 2'b00, 2'b10, 0, 9);
    cycle(0, 1, 599, 2'b00, 2'b11, 4, 4);
    chk("cfg_iv_pos", 64'(POSITION), 64'd0);
    chk("cfg_iv_pv", 64'(POS_VALID), 64'd0);
    cycle(0, 0, 0, 2'b00, 2'b11, 10, 20);
    cycle(0, 0, 0, 2'b10, 2'b11, 1, 1);
    chk("clr1_ch0", 64'(POSITION[9:0]), 64'd11);
    chk("clr1_ch1", 64'(POSITION[19:10]), 64'd0);
    cycle(0, 1, 0, 2'b00, 2'b00, 0, 0);
    cycle(0, 0, 0, 2'b00, 2'b11, 0, 1);
    chk("ppr0_err", 64'(ERR), 64'b10);
    for (int k = 0; k < 20; k++)
      cycle(0, k == 0, 599, 2'(k % 5 == 4), 2'($urandom_range(0, 3)),
            $urandom_range(0, 1000) - 500, $urandom_range(0, 1000) - 500);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pos_wrap_accum.md
Name: pos_wrap_accum

Overview:
Multi-channel registered encoder position accumulator. Each channel adds a signed per-sample count delta to its stored position. The result is wrapped modulo (PPR+1) into the range 0..PPR, with wrap-direction pulses. This is the sequential, parametrised successor to the combinational position converter. It sits between the quadrature/count front end and the motion-control datapath.

Parameters:
W, 10, position width; PPR and per-channel delta width
CH, 2, number of independent channels
RW, 16, signed revolution counter width (used only with REV_COUNT_EN)
PPR_RST, 599, PPR register value after reset

Ports:
CLK  input  1  rising-edge clock
RST  input  1  synchronous active-high reset
CFG_WE  input  1  load PPR into the shared register; clears all channels
PPR  input  W  maximum count (unsigned); channel range is 0..PPR
CLR  input  CH  per-channel position/error/revolution clear
IN_VALID  input  CH  per-channel delta strobe
DELTA  input  CH*W  per-channel signed two's-complement delta; channel i is bits [i*W +: W]
POS_VALID  output  CH  one-cycle pulse when a delta has been accepted
POSITION  output  CH*W  per-channel wrapped position, unsigned
WRAP_FWD  output  CH  one-cycle pulse on forward wrap (PPR -> 0 crossing)
WRAP_REV  output  CH  one-cycle pulse on reverse wrap (0 -> PPR crossing)
ERR  output  CH  sticky error: a delta with |DELTA| > PPR_reg was rejected
REV  output  CH*RW  per-channel signed revolution count (only with REV_COUNT_EN)

Behaviour:
- Reset (RST high at a CLK edge): PPR_reg=PPR_RST. All POSITION, ERR and REV are 0. All POS_VALID, WRAP_FWD and WRAP_REV are 0. RST overrides every other input.
- Priority per channel, highest first: RST > CFG_WE > CLR[i] > IN_VALID[i].
- CFG_WE: PPR_reg<=PPR. All channels go to POSITION=0, ERR=0, REV=0. No POS_VALID. Any IN_VALID in the same cycle is dropped.
- CLR[i]: channel i goes to POSITION=0, ERR=0, REV=0. No POS_VALID. A simultaneous IN_VALID[i] is dropped.
- Accept (IN_VALID[i], no higher-priority event):
  - Compute in W+2 bit signed: s = POSITION + DELTA.
  - If |DELTA| > PPR_reg: ERR[i]<=1, POSITION unchanged, no wrap pulse.
  - If |DELTA| <= PPR_reg and s > PPR_reg: POSITION <= s-(PPR_reg+1), WRAP_FWD pulse, REV+1.
  - If |DELTA| <= PPR_reg and s < 0: POSITION <= s+PPR_reg+1, WRAP_REV pulse, REV-1.
  - Otherwise: POSITION <= s.
  - POS_VALID[i] pulses in every accept case, including rejection.
- |DELTA| is computed in W+1 bits, so DELTA = -2^(W-1) is handled without overflow.
- Latency: 1 cycle. Outputs are registered and valid the cycle after IN_VALID.
- Throughput: one delta per channel per cycle. Channels are fully independent.
- POS_VALID, WRAP_FWD and WRAP_REV are single-cycle pulses. They are 0 in any cycle with no accept.
- DELTA=0 accepted: POS_VALID pulses, no wrap pulse.
- If the position is exactly PPR_reg and DELTA=+1: POSITION=0, WRAP_FWD.
- If the position is 0 and DELTA=-1: POSITION=PPR_reg, WRAP_REV.
- PPR=0 via CFG_WE is legal. Every nonzero delta is then rejected.
- The REV counter wraps modulo 2^RW silently.

Optional Feature:
REV_COUNT_EN
- Defined: REV port present; per-channel RW-bit signed counter updated as above, cleared by RST, CFG_WE and CLR.
- Undefined: REV port and counters are absent. All other behaviour is identical.

Decomposition:
- Package pos_wrap_pkg holds:
  - default W, CH, RW, PPR_RST constants;
  - the W+2 sum width constant;
  - a function extracting channel i's slice from a packed vector.
- Sub-module pos_wrap_ch implements one channel's accumulate/wrap/error/REV logic.
- Top instantiates pos_wrap_ch CH times via generate and owns PPR_reg and the CFG_WE broadcast.

Test Plan:
- Reset, then CFG_WE PPR=599. Ch0 deltas +200, -127, -188, +144 on consecutive cycles -> POSITION 200, 73, 485 (WRAP_REV), 29 (WRAP_FWD). Each result appears 1 cycle after its delta, with POS_VALID each cycle. REV goes 0, 0, -1, 0.
- PPR=599, position 0, delta -127 -> 473 with WRAP_REV. Position 599, delta +1 -> 0 with WRAP_FWD. Position 0, delta -1 -> 599.
- CFG_WE PPR=399, delta -450 -> ERR[0]=1, POSITION stays 0, POS_VALID=1, no wraps. Then CLR[0] -> ERR=0. Delta +200 -> 200.
- Ch0 and ch1 given different deltas in the same cycle (+5, -5) at PPR=399 -> ch0=5, ch1=395 with WRAP_REV on ch1 only.
- With positions nonzero, assert CFG_WE, IN_VALID and RST in combinations: RST wins (PPR_reg=599, all zero). CFG_WE with IN_VALID leaves all positions 0, no POS_VALID. CLR[1] with IN_VALID[1] leaves ch1 at 0 while ch0 updates.
- Build without REV_COUNT_EN: repeat the first scenario -> identical POSITION and pulses, and no REV port is present.
